// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan bus (driver and capture sides).
// Bit order on the segment bus is bit0=a .. bit6=g, digit i in code[7i+6:7i].
// Holds the FSM state encoding, bus geometry, glyph constants and index helpers.
package seg_pkg;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;
  localparam int CODE_W = DIGITS * SEG_W;

  // FSM state encoding: IDLE waits for digit0, COLLECT gathers digits 1..3.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_COLLECT = 1'b1;

  localparam logic [SEG_W-1:0] G_0 = 7'h3F;
  localparam logic [SEG_W-1:0] G_1 = 7'h06;
  localparam logic [SEG_W-1:0] G_2 = 7'h5B;
  localparam logic [SEG_W-1:0] G_3 = 7'h4F;
  localparam logic [SEG_W-1:0] G_4 = 7'h66;
  localparam logic [SEG_W-1:0] G_5 = 7'h6D;
  localparam logic [SEG_W-1:0] G_6 = 7'h7D;
  localparam logic [SEG_W-1:0] G_7 = 7'h07;
  localparam logic [SEG_W-1:0] G_8 = 7'h7F;
  localparam logic [SEG_W-1:0] G_9 = 7'h6F;
  localparam logic [SEG_W-1:0] G_A = 7'h77;
  localparam logic [SEG_W-1:0] G_B = 7'h7C;
  localparam logic [SEG_W-1:0] G_C = 7'h39;
  localparam logic [SEG_W-1:0] G_D = 7'h5E;
  localparam logic [SEG_W-1:0] G_E = 7'h79;
  localparam logic [SEG_W-1:0] G_F = 7'h71;

  // Entry k is the glyph for nibble k.
  localparam logic [15:0][SEG_W-1:0] GLYPH_TAB = {
    G_F, G_E, G_D, G_C, G_B, G_A, G_9, G_8,
    G_7, G_6, G_5, G_4, G_3, G_2, G_1, G_0
  };

  function automatic logic is_onehot4(input logic [DIGITS-1:0] cs);
    return (cs != '0) && ((cs & (cs - 1'b1)) == '0);
  endfunction

  // Index of the set bit; only meaningful when cs is one-hot.
  function automatic logic [1:0] onehot_idx(input logic [DIGITS-1:0] cs);
    logic [1:0] idx;
    idx = 2'd0;
    if (cs[1]) idx = 2'd1;
    if (cs[2]) idx = 2'd2;
    if (cs[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Glyph-to-nibble decoder: maps one 7-segment pattern to its hex digit.
// Ports: glyph (7-bit segment pattern in), ok (legal glyph), nibble (0..F, 0 if unknown).
// Purely combinational, no state.
import seg_pkg::*;

module seg_hex_dec (
  input  logic [SEG_W-1:0] glyph,
  output logic             ok,
  output logic [3:0]       nibble
);

  always_comb begin
    ok     = 1'b0;
    nibble = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (glyph == GLYPH_TAB[k]) begin
        ok     = 1'b1;
        nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the 4-digit multiplexed 7-segment scan bus: rebuilds the 28-bit code.
// Ports: clk_sc/rst_n; seg_cs_in, seg_data_in (async pins); code_o/code_valid, blank_o,
//        frame_err; hex_o/hex_ok only when SEG_HEX_DECODE_EN is defined.
// Latency: SETTLE_CYC+3 edges from pin sample to code_valid; no backpressure (pulses only).
import seg_pkg::*;

module seg_scan_capture #(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_sc,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] seg_cs_in,
  input  logic [SEG_W-1:0]  seg_data_in,
  output logic [CODE_W-1:0] code_o,
  output logic              code_valid,
  output logic              blank_o,
  output logic              frame_err
`ifdef SEG_HEX_DECODE_EN
  ,
  output logic [15:0]       hex_o,
  output logic              hex_ok
`endif
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [DIGITS-1:0]         cs_m, cs_s, cs_p;
  logic [SEG_W-1:0]          seg_m, seg_s, seg_p;
  logic [SW-1:0]             stab_cnt;
  logic                      chg, accept;
  state_t                    state;
  logic [1:0]                exp_idx;
  logic [TW-1:0]             tmo_cnt;
  logic [2:0][SEG_W-1:0]     slots;
  logic [1:0]                idx;
  logic [CODE_W-1:0]         next_code;

  // cs_p/seg_p is the previous synchronised value; a mismatch against cs_s/seg_s
  // marks a change. The counter saturates one past the accept point so accept
  // fires exactly once per stable value.
  assign chg    = {cs_s, seg_s} != {cs_p, seg_p};
  assign accept = !chg && (stab_cnt == SW'(SETTLE_CYC - 1));
  assign idx    = onehot_idx(cs_p);
  assign next_code = {seg_p, slots[2], slots[1], slots[0]};

  always_ff @(posedge clk_sc or negedge rst_n) begin
    if (!rst_n) begin
      cs_m     <= '0;
      cs_s     <= '0;
      cs_p     <= '0;
      seg_m    <= '0;
      seg_s    <= '0;
      seg_p    <= '0;
      stab_cnt <= '0;
    end else begin
      cs_m  <= seg_cs_in;
      cs_s  <= cs_m;
      seg_m <= seg_data_in;
      seg_s <= seg_m;
      cs_p  <= cs_s;
      seg_p <= seg_s;
      if (chg)
        stab_cnt <= '0;
      else if (stab_cnt != SW'(SETTLE_CYC))
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

`ifdef SEG_HEX_DECODE_EN
  logic [DIGITS-1:0]      dec_ok;
  logic [DIGITS-1:0][3:0] dec_nib;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dec
    seg_hex_dec u_dec (
      .glyph  (next_code[d*SEG_W +: SEG_W]),
      .ok     (dec_ok[d]),
      .nibble (dec_nib[d])
    );
  end
`endif

  always_ff @(posedge clk_sc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      exp_idx    <= 2'd0;
      tmo_cnt    <= '0;
      slots      <= '0;
      code_o     <= '0;
      code_valid <= 1'b0;
      blank_o    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SEG_HEX_DECODE_EN
      hex_o      <= '0;
      hex_ok     <= 1'b0;
`endif
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (accept) begin
        tmo_cnt <= '0;
        if (cs_p == '0) begin
          blank_o <= 1'b1;
          state   <= ST_IDLE;
        end else begin
          blank_o <= 1'b0;
          if (!is_onehot4(cs_p)) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (state == ST_IDLE) begin
            // Mid-frame digits seen while idle are the tail of a frame we joined late.
            if (idx == 2'd0) begin
              slots[0] <= seg_p;
              exp_idx  <= 2'd1;
              state    <= ST_COLLECT;
            end
          end else if (idx == exp_idx) begin
            if (idx == 2'd3) begin
              code_o     <= next_code;
              code_valid <= 1'b1;
              state      <= ST_IDLE;
`ifdef SEG_HEX_DECODE_EN
              hex_o      <= dec_nib;
              hex_ok     <= &dec_ok;
`endif
            end else begin
              slots[idx] <= seg_p;
              exp_idx    <= exp_idx + 2'd1;
            end
          end else if (idx == exp_idx - 2'd1) begin
            // Segments changed while the same digit was still selected.
            slots[idx] <= seg_p;
          end else begin
            frame_err <= 1'b1;
            if (idx == 2'd0) begin
              slots[0] <= seg_p;
              exp_idx  <= 2'd1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      end else if (state == ST_COLLECT) begin
        if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          frame_err <= 1'b1;
          state     <= ST_IDLE;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: table of dwell vectors plus hand-written multi-cycle cases.
module tb_seg_scan_capture;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1024;
  localparam int NV      = 29;

  localparam logic [27:0] K1 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [27:0] K2 = {7'h07, 7'h7D, 7'h6D, 7'h66};
  localparam logic [27:0] K3 = {7'h4F, 7'h5B, 7'h00, 7'h3F};
  localparam logic [27:0] K4 = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] K5 = {7'h71, 7'h79, 7'h5E, 7'h39};

  logic        clk_sc = 1'b0;
  logic        rst_n;
  logic [3:0]  seg_cs_in;
  logic [6:0]  seg_data_in;
  logic [27:0] code_o;
  logic        code_valid, blank_o, frame_err;
`ifdef SEG_HEX_DECODE_EN
  logic [15:0] hex_o;
  logic        hex_ok;
`endif

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic overlap = 1'b0;

  always #5 clk_sc = ~clk_sc;

  seg_scan_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk_sc      (clk_sc),
    .rst_n       (rst_n),
    .seg_cs_in   (seg_cs_in),
    .seg_data_in (seg_data_in),
    .code_o      (code_o),
    .code_valid  (code_valid),
    .blank_o     (blank_o),
    .frame_err   (frame_err)
`ifdef SEG_HEX_DECODE_EN
    ,
    .hex_o       (hex_o),
    .hex_ok      (hex_ok)
`endif
  );

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk_sc) begin
    if (code_valid) vcnt++;
    if (frame_err) ecnt++;
    if (code_valid && frame_err) overlap = 1'b1;
  end

  typedef struct {
    logic [3:0]  cs;
    logic [6:0]  seg;
    int          exp_v;
    int          exp_e;
    logic        exp_blank;
    logic [27:0] exp_code;
    logic [15:0] exp_hex;
    logic        exp_ok;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input logic [3:0] cs, input logic [6:0] seg, input int v,
                              input int e, input logic bl, input logic [27:0] code,
                              input logic [15:0] hx, input logic ok);
    vec_t r;
    r.cs = cs; r.seg = seg; r.exp_v = v; r.exp_e = e; r.exp_blank = bl;
    r.exp_code = code; r.exp_hex = hx; r.exp_ok = ok;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic apply(input logic [3:0] cs, input logic [6:0] seg, input int dwell);
    seg_cs_in   = cs;
    seg_data_in = seg;
    repeat (dwell) @(posedge clk_sc);
    #1;
  endtask

  int v0, e0, n;

  initial begin
    // ordered frame
    vt[0]  = mk(4'b0001, 7'h3F, 0, 0, 0, 28'h0, 16'h0, 0);
    vt[1]  = mk(4'b0010, 7'h06, 0, 0, 0, 28'h0, 16'h0, 0);
    vt[2]  = mk(4'b0100, 7'h5B, 0, 0, 0, 28'h0, 16'h0, 0);
    vt[3]  = mk(4'b1000, 7'h4F, 1, 0, 0, K1, 16'h3210, 1);
    // join mid-frame: leading digit ignored
    vt[4]  = mk(4'b0100, 7'h5B, 0, 0, 0, K1, 16'h3210, 1);
    vt[5]  = mk(4'b0001, 7'h66, 0, 0, 0, K1, 16'h3210, 1);
    vt[6]  = mk(4'b0010, 7'h6D, 0, 0, 0, K1, 16'h3210, 1);
    vt[7]  = mk(4'b0100, 7'h7D, 0, 0, 0, K1, 16'h3210, 1);
    vt[8]  = mk(4'b1000, 7'h07, 1, 0, 0, K2, 16'h7654, 1);
    // skipped digit -> error, then idle ignores digit3
    vt[9]  = mk(4'b0001, 7'h3F, 0, 0, 0, K2, 16'h7654, 1);
    vt[10] = mk(4'b0100, 7'h5B, 0, 1, 0, K2, 16'h7654, 1);
    vt[11] = mk(4'b1000, 7'h4F, 0, 0, 0, K2, 16'h7654, 1);
    // non-one-hot, blank, then frame with an unknown glyph
    vt[12] = mk(4'b0011, 7'h3F, 0, 1, 0, K2, 16'h7654, 1);
    vt[13] = mk(4'b0000, 7'h00, 0, 0, 1, K2, 16'h7654, 1);
    vt[14] = mk(4'b0001, 7'h3F, 0, 0, 0, K2, 16'h7654, 1);
    vt[15] = mk(4'b0010, 7'h00, 0, 0, 0, K2, 16'h7654, 1);
    vt[16] = mk(4'b0100, 7'h5B, 0, 0, 0, K2, 16'h7654, 1);
    vt[17] = mk(4'b1000, 7'h4F, 1, 0, 0, K3, 16'h3200, 0);
    // same digit re-accepted with new segments overwrites the slot
    vt[18] = mk(4'b0001, 7'h3F, 0, 0, 0, K3, 16'h3200, 0);
    vt[19] = mk(4'b0001, 7'h06, 0, 0, 0, K3, 16'h3200, 0);
    vt[20] = mk(4'b0010, 7'h5B, 0, 0, 0, K3, 16'h3200, 0);
    vt[21] = mk(4'b0100, 7'h4F, 0, 0, 0, K3, 16'h3200, 0);
    vt[22] = mk(4'b1000, 7'h66, 1, 0, 0, K4, 16'h4321, 1);
    // out-of-order digit0 restarts the frame with an error
    vt[23] = mk(4'b0001, 7'h77, 0, 0, 0, K4, 16'h4321, 1);
    vt[24] = mk(4'b0010, 7'h7C, 0, 0, 0, K4, 16'h4321, 1);
    vt[25] = mk(4'b0001, 7'h39, 0, 1, 0, K4, 16'h4321, 1);
    vt[26] = mk(4'b0010, 7'h5E, 0, 0, 0, K4, 16'h4321, 1);
    vt[27] = mk(4'b0100, 7'h79, 0, 0, 0, K4, 16'h4321, 1);
    vt[28] = mk(4'b1000, 7'h71, 1, 0, 0, K5, 16'hFEDC, 1);

    seg_cs_in = 4'b0000;
    seg_data_in = 7'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_sc);
    #1;
    chk("reset code_o", code_o, 0);
    chk("reset code_valid", code_valid, 0);
    chk("reset blank_o", blank_o, 0);
    chk("reset frame_err", frame_err, 0);
`ifdef SEG_HEX_DECODE_EN
    chk("reset hex_o", hex_o, 0);
    chk("reset hex_ok", hex_ok, 0);
`endif
    rst_n = 1'b1;
    repeat (10) @(posedge clk_sc);
    #1;

    for (int i = 0; i < NV; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      apply(vt[i].cs, vt[i].seg, 8);
      chk($sformatf("v%0d code_valid count", i), vcnt - v0, vt[i].exp_v);
      chk($sformatf("v%0d frame_err count", i), ecnt - e0, vt[i].exp_e);
      chk($sformatf("v%0d code_o", i), code_o, vt[i].exp_code);
      chk($sformatf("v%0d blank_o", i), blank_o, vt[i].exp_blank);
`ifdef SEG_HEX_DECODE_EN
      chk($sformatf("v%0d hex_o", i), hex_o, vt[i].exp_hex);
      chk($sformatf("v%0d hex_ok", i), hex_ok, vt[i].exp_ok);
`endif
    end

    // Latency: edge 1 is the first edge sampling digit3; code_valid after edge SETTLE+3.
    apply(4'b0001, 7'h3F, 8);
    apply(4'b0010, 7'h06, 8);
    apply(4'b0100, 7'h5B, 8);
    seg_cs_in = 4'b1000;
    seg_data_in = 7'h4F;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_sc);
      #1;
      if (code_valid) begin
        n = k;
        break;
      end
    end
    chk("latency edges to code_valid", n, SETTLE + 3);
    chk("latency code_o", code_o, K1);
    apply(4'b1000, 7'h4F, 6);

    // Timeout: stall after digit1; error 1024 edges after the edge that accepted it.
    apply(4'b0001, 7'h3F, 8);
    e0 = ecnt;
    seg_cs_in = 4'b0010;
    seg_data_in = 7'h06;
    n = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(posedge clk_sc);
      #1;
      if (frame_err) begin
        n = k;
        break;
      end
    end
    chk("timeout edges to frame_err", n, SETTLE + 3 + TIMEOUT);
    repeat (20) @(posedge clk_sc);
    #1;
    chk("timeout single pulse", ecnt - e0, 1);
    chk("timeout code_o kept", code_o, K1);
    v0 = vcnt;
    apply(4'b0001, 7'h66, 8);
    apply(4'b0010, 7'h6D, 8);
    apply(4'b0100, 7'h7D, 8);
    apply(4'b1000, 7'h07, 8);
    chk("after timeout code_valid count", vcnt - v0, 1);
    chk("after timeout code_o", code_o, K2);

    // One-cycle glitch to an out-of-order digit must not be accepted.
    apply(4'b0001, 7'h3F, 8);
    e0 = ecnt;
    v0 = vcnt;
    apply(4'b0100, 7'h5B, 1);
    apply(4'b0001, 7'h3F, 10);
    chk("glitch frame_err count", ecnt - e0, 0);
    apply(4'b0010, 7'h06, 8);
    apply(4'b0100, 7'h5B, 8);
    apply(4'b1000, 7'h4F, 8);
    chk("glitch frame code_valid count", vcnt - v0, 1);
    chk("glitch frame code_o", code_o, K1);

    // Reset mid-frame discards partial slots.
    apply(4'b0001, 7'h66, 8);
    apply(4'b0010, 7'h6D, 8);
    rst_n = 1'b0;
    #1;
    chk("midreset code_o", code_o, 0);
    chk("midreset code_valid", code_valid, 0);
    chk("midreset blank_o", blank_o, 0);
    chk("midreset frame_err", frame_err, 0);
`ifdef SEG_HEX_DECODE_EN
    chk("midreset hex_o", hex_o, 0);
    chk("midreset hex_ok", hex_ok, 0);
`endif
    repeat (3) @(posedge clk_sc);
    #1;
    rst_n = 1'b1;
    v0 = vcnt;
    apply(4'b0100, 7'h7D, 8);
    apply(4'b1000, 7'h07, 8);
    chk("after reset code_valid count", vcnt - v0, 0);
    chk("after reset code_o", code_o, 0);

    chk("code_valid/frame_err overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
